key_pio_poller: RTL and testbench

// - Avalon-MM read master that polls the KEY input PIO slave (offset 0, data register) at a fixed rate.
// - Debounces each key bit and converts key presses into sticky events for the reaction-timer control logic.
// - Presses are held in a sticky register until the consumer acknowledges them.
// - Sits between the KEY PIO slave and the reaction-timer control FSM; no Nios software is involved in the key path.
//

---
 rtl/key_pio_poller.sv | 134 +++++++++++++
 tb/tb_key_pio_poller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_pio_poller.sv
// key_pio_poller: Avalon-MM read master that samples the KEY PIO data register
// at a fixed rate, debounces every key bit and latches press events until the
// reaction-timer control logic acknowledges them.
module key_pio_poller #(
  parameter int WIDTH            = 3,
  parameter int POLL_CYCLES      = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic             event_valid,
  input  logic             event_ack
);

  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    UPDATE
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic             poll_due;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] raw;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] new_press;
  logic             unused_readdata;

  // Only one PIO register is ever read, so the address is tied to the data register.
  assign avm_address = 2'd0;
  assign poll_due    = (timer == TIMER_LAST);
  assign event_valid = |key_press;

  // Bring key bits to "1 = pressed"; bits above WIDTH are deliberately ignored.
  assign sample          = (ACTIVE_LOW != 0) ? ~avm_readdata[WIDTH-1:0] : avm_readdata[WIDTH-1:0];
  assign unused_readdata = ^avm_readdata;

  // Free-running poll timer, independent of the FSM so the poll period never drifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (poll_due) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Poll sequencer: issues a single-cycle read strobe, then walks through capture and update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      avm_read <= 1'b0;
    end else begin
      avm_read <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_due) begin
            state    <= READ;
            avm_read <= 1'b1;
          end
        end
        READ:    state <= CAPTURE;
        CAPTURE: state <= UPDATE;
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the slave's answer in the cycle after the read strobe (fixed 1-cycle latency).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw <= '0;
    end else if (state == CAPTURE) begin
      raw <= sample;
    end
  end

  // Per-bit debounce: a level flips only after DEBOUNCE_SAMPLES consecutive disagreeing polls.
  always_comb begin
    level_next = key_level;
    new_press  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
    end
    if (state == UPDATE) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (raw[i] == key_level[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          level_next[i] = ~key_level[i];
          cnt_next[i]   = '0;
          new_press[i]  = ~key_level[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Commit debounced levels and sticky press events; a new press beats a simultaneous ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_level <= '0;
      key_press <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      key_level <= level_next;
      key_press <= (key_press & ~{WIDTH{event_ack}}) | new_press;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_key_pio_poller.sv
// tb_key_pio_poller: drives key patterns through a registered PIO slave model and
// checks debounced levels and sticky press events after every poll.
module tb_key_pio_poller;

  localparam int WIDTH  = 3;
  localparam int PERIOD = 8;

  logic             clk;
  logic             reset_n;
  logic [1:0]       avm_address;
  logic             avm_read;
  logic [31:0]      avm_readdata;
  logic [WIDTH-1:0] key_level;
  logic [WIDTH-1:0] key_press;
  logic             event_valid;
  logic             event_ack;

  logic [WIDTH-1:0] in_port;
  logic [31:0]      noise;

  typedef struct {
    logic [WIDTH-1:0] in_port;
    logic             ack;
    logic [WIDTH-1:0] exp_level;
    logic [WIDTH-1:0] exp_press;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press;
  } exp_t;

  vec_t             vecs[$];
  exp_t             sb_q[$];
  int               checks;
  int               fails;
  int               cyc;
  int               last_read_cyc;
  logic [WIDTH-1:0] prev_level;
  bit               found;

  key_pio_poller #(
    .WIDTH(WIDTH),
    .POLL_CYCLES(PERIOD),
    .DEBOUNCE_SAMPLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .key_level(key_level),
    .key_press(key_press),
    .event_valid(event_valid),
    .event_ack(event_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure the poll period.
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model: registered read data, junk in the unused upper bits.
  always @(posedge clk) begin
    if (avm_read) begin
      noise = $urandom();
      avm_readdata <= {noise[31:WIDTH], in_port};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Wait (bounded) for the next read strobe; returns at the negedge inside the READ cycle.
  task automatic waitRead(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      if (avm_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("[TB] FAIL read_timeout: got no avm_read, expected one within %0d cycles", 4 * PERIOD);
    end
  endtask

  // Drive one poll's worth of stimulus, optionally acking during UPDATE, and score the result.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   ok;
    in_port = v.in_port;
    sb_q.push_back('{level: v.exp_level, press: v.exp_press});
    waitRead(ok);
    if (ok) begin
      checkOutput("poll_period", cyc - last_read_cyc, PERIOD);
      last_read_cyc = cyc;
      checkOutput("avm_address", {30'd0, avm_address}, 32'd0);
      @(negedge clk);
      checkOutput("read_width", {31'd0, avm_read}, 32'd0);
      @(negedge clk);
      checkOutput("level_before_update", {29'd0, key_level}, {29'd0, prev_level});
      event_ack = v.ack;
      @(negedge clk);
      event_ack = 1'b0;
    end
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput("key_level", {29'd0, key_level}, {29'd0, e.level});
      checkOutput("key_press", {29'd0, key_press}, {29'd0, e.press});
      checkOutput("event_valid", {31'd0, event_valid}, {31'd0, |e.press});
      prev_level = e.level;
    end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    cyc           = 0;
    prev_level    = '0;
    avm_readdata  = '0;
    reset_n       = 1'b0;
    in_port       = 3'b111;
    event_ack     = 1'b0;

    // in_port, ack during UPDATE, expected key_level, expected key_press
    vecs.push_back('{3'b111, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b001, 3'b001});
    vecs.push_back('{3'b100, 1'b0, 3'b001, 3'b001});
    vecs.push_back('{3'b100, 1'b0, 3'b001, 3'b001});
    vecs.push_back('{3'b100, 1'b0, 3'b001, 3'b001});
    vecs.push_back('{3'b100, 1'b1, 3'b011, 3'b010});
    vecs.push_back('{3'b100, 1'b1, 3'b011, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b011, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b011, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b011, 3'b000});
    vecs.push_back('{3'b111, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b1, 3'b000, 3'b000});
    vecs.push_back('{3'b110, 1'b0, 3'b001, 3'b001});

    repeat (3) @(negedge clk);
    checkOutput("reset_avm_read", {31'd0, avm_read}, 32'd0);
    checkOutput("reset_key_level", {29'd0, key_level}, 32'd0);
    checkOutput("reset_key_press", {29'd0, key_press}, 32'd0);
    checkOutput("reset_event_valid", {31'd0, event_valid}, 32'd0);

    reset_n       = 1'b1;
    last_read_cyc = cyc;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end

    // Reset asserted in the middle of a READ cycle.
    in_port = 3'b110;
    waitRead(found);
    if (found) begin
      checkOutput("poll_period_pre_reset", cyc - last_read_cyc, PERIOD);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_avm_read", {31'd0, avm_read}, 32'd0);
      checkOutput("midreset_key_level", {29'd0, key_level}, 32'd0);
      checkOutput("midreset_key_press", {29'd0, key_press}, 32'd0);
      checkOutput("midreset_event_valid", {31'd0, event_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n       = 1'b1;
      last_read_cyc = cyc;
      prev_level    = '0;
      applyStimulus('{3'b111, 1'b0, 3'b000, 3'b000});
      applyStimulus('{3'b110, 1'b0, 3'b000, 3'b000});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the bench cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
